// File: rtl/data_memory_ws.sv
`default_nettype none
// ============================================================================
// Module  : data_memory_ws
// Brief   : Wait-state data memory with valid/ready request handshake,
//           byte-enable writes and out-of-range error reporting.
// Revision: 1.0 - initial release
// ============================================================================
module data_memory_ws #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int              c_BE_W  = DATA_W / 8;
    localparam int              c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      c_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [c_BE_W-1:0]   be_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                resp_err_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                w_in_range;
    logic [c_IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0]   w_rd_word;
    logic [DATA_W-1:0]   w_merged;
    logic                w_access;
    logic                w_mem_we;

    // Full-width compare so addresses past DEPTH never alias onto real words.
    assign w_in_range = ({1'b0, addr_q} < c_DEPTH);
    assign w_idx      = addr_q[c_IDX_W-1:0];
    assign w_access   = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign w_mem_we   = w_access && write_q && w_in_range;

    always_comb begin
        w_rd_word = '0;
        if (w_in_range) begin
            w_rd_word = mem[w_idx];
        end
        w_merged = w_rd_word;
        for (int i = 0; i < c_BE_W; i++) begin
            if (be_q[i]) begin
                w_merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        cnt_q   <= c_WAIT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= ~w_in_range;
                        resp_rdata_q <= w_in_range ? (write_q ? w_merged : w_rd_word) : '0;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ws.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_memory_ws
// Brief   : Directed self-checking bench; instance A (DEPTH=200, 2 waits),
//           instance B (zero waits) for back-to-back streaming.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_memory_ws;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr  = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be    = '0;

    logic        a_valid, a_ready, a_rv, a_err, a_busy;
    logic [15:0] a_rdata;
    logic        b_valid, b_ready, b_rv, b_err, b_busy;
    logic [15:0] b_rdata;
    logic        rdy, rv, err, bsy;
    logic [15:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign a_valid = req_valid & ~sel;
    assign b_valid = req_valid & sel;
    assign rdy     = sel ? b_ready : a_ready;
    assign rv      = sel ? b_rv    : a_rv;
    assign err     = sel ? b_err   : a_err;
    assign bsy     = sel ? b_busy  : a_busy;
    assign rdata   = sel ? b_rdata : a_rdata;

    data_memory_ws #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .resp_valid(a_rv), .resp_rdata(a_rdata),
        .resp_err(a_err), .busy(a_busy)
    );

    data_memory_ws #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .resp_valid(b_rv), .resp_rdata(b_rdata),
        .resp_err(b_err), .busy(b_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One complete transaction; request inputs are scrambled while in flight.
    task automatic txn(input string tag, input logic wr, input logic [7:0] addr,
                       input logic [15:0] wd, input logic [1:0] be,
                       input logic [15:0] exp_rd, input logic exp_err);
        int n;
        int ready_lo;
        int exp_lat;
        exp_lat = sel ? 1 : 3;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_accept_to"}, 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq({tag, "_busy"}, 32'(bsy), 32'd1);
        n = 0;
        ready_lo = 0;
        while (!rv && n < 20) begin
            if (!rdy) ready_lo++;
            req_write = 1'($urandom); req_addr = 8'($urandom);
            req_wdata = 16'($urandom); req_be = 2'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) ready_lo++;
        check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_eq({tag, "_ready_lo"}, 32'(ready_lo), 32'(exp_lat + 1));
        check_eq({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        @(posedge clk);
        #1;
        check_eq({tag, "_rv_drop"}, 32'(rv), 32'd0);
        check_eq({tag, "_ready_back"}, 32'(rdy), 32'd1);
        check_eq({tag, "_rdata_hold"}, 32'(rdata), 32'(exp_rd));
    endtask

    initial begin
        int pulses;
        int k;
        int acc_cyc[3];
        int rsp_idx;
        logic rdy_pre;

        #2 rst = 1'b1;
        #1;
        check_eq("rst_rv", 32'(a_rv), 32'd0);
        check_eq("rst_rdata", 32'(a_rdata), 32'd0);
        check_eq("rst_err", 32'(a_err), 32'd0);
        check_eq("rst_busy", 32'(a_busy), 32'd0);
        check_eq("rst_ready", 32'(a_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(a_ready), 32'd1);

        txn("t1_wr", 1'b1, 8'h04, 16'hABCD, 2'b11, 16'hABCD, 1'b0);
        txn("t1_rd", 1'b0, 8'h04, 16'h0000, 2'b00, 16'hABCD, 1'b0);

        txn("t2_wr_lo", 1'b1, 8'h04, 16'h1234, 2'b01, 16'hAB34, 1'b0);
        txn("t2_rd_lo", 1'b0, 8'h04, 16'h0000, 2'b00, 16'hAB34, 1'b0);
        txn("t2_wr_be0", 1'b1, 8'h04, 16'hFFFF, 2'b00, 16'hAB34, 1'b0);
        txn("t2_rd_be0", 1'b0, 8'h04, 16'h0000, 2'b11, 16'hAB34, 1'b0);
        txn("t2_wr_hi", 1'b1, 8'h04, 16'h9900, 2'b10, 16'h9934, 1'b0);

        txn("t3_wr_7e", 1'b1, 8'h7E, 16'h2222, 2'b11, 16'h2222, 1'b0);
        txn("t3_wr_fe", 1'b1, 8'hFE, 16'h1234, 2'b11, 16'h0000, 1'b1);
        txn("t3_rd_fe", 1'b0, 8'hFE, 16'h0000, 2'b00, 16'h0000, 1'b1);
        txn("t3_rd_7e", 1'b0, 8'h7E, 16'h0000, 2'b00, 16'h2222, 1'b0);
        txn("t3_wr_c7", 1'b1, 8'hC7, 16'h5A5A, 2'b11, 16'h5A5A, 1'b0);
        txn("t3_rd_c8", 1'b0, 8'hC8, 16'h0000, 2'b00, 16'h0000, 1'b1);
        txn("t3_rd_c7", 1'b0, 8'hC7, 16'h0000, 2'b00, 16'h5A5A, 1'b0);

        txn("t4_wr_a", 1'b1, 8'h06, 16'h1111, 2'b11, 16'h1111, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h06; req_wdata = 16'h5678; req_be = 2'b11;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("t4_busy_acc", 32'(a_busy), 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("t4_busy_rst", 32'(a_busy), 32'd0);
        check_eq("t4_rv_rst", 32'(a_rv), 32'd0);
        check_eq("t4_ready_rst", 32'(a_ready), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_eq("t4_ready_rel", 32'(a_ready), 32'd1);
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (a_rv) pulses++;
        end
        check_eq("t4_no_pulse", 32'(pulses), 32'd0);
        txn("t4_rd", 1'b0, 8'h06, 16'h0000, 2'b00, 16'h1111, 1'b0);

        sel = 1'b1;
        txn("t5_pw0", 1'b1, 8'h00, 16'h000A, 2'b11, 16'h000A, 1'b0);
        txn("t5_pw1", 1'b1, 8'h01, 16'h000B, 2'b11, 16'h000B, 1'b0);
        txn("t5_pw2", 1'b1, 8'h02, 16'h000C, 2'b11, 16'h000C, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h00; req_be = 2'b11;
        k = 0;
        rsp_idx = 0;
        for (int cyc = 0; cyc < 20 && rsp_idx < 3; cyc++) begin
            rdy_pre = b_ready;
            @(posedge clk);
            #1;
            if (b_rv) begin
                check_eq($sformatf("t5_data%0d", rsp_idx), 32'(b_rdata), 32'h0A + 32'(rsp_idx));
                check_eq($sformatf("t5_lat%0d", rsp_idx), 32'(cyc - acc_cyc[rsp_idx]), 32'd1);
                rsp_idx++;
            end
            if (rdy_pre && req_valid) begin
                acc_cyc[k] = cyc;
                if (k > 0) check_eq($sformatf("t5_gap%0d", k), 32'(cyc - acc_cyc[k-1]), 32'd3);
                k++;
                req_addr = 8'(k);
                if (k == 3) req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check_eq("t5_resp_count", 32'(rsp_idx), 32'd3);
        sel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
